// File: rtl/rr_arb.sv
// Round-robin arbiter with registered grant held until ack.
// Optional RR_ARB_BURST_EN lets one requester hold up to BURST grants in a row.
module rr_arb #(
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 ack_i,
  output logic                 gnt_vld_o,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_enc_o
);

  localparam int W = $clog2(N);

  if (N < 2 || BURST < 1) begin : g_bad_param
    $error("rr_arb: need N >= 2 and BURST >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [W-1:0]   ptr, ptr_n;
  logic [W-1:0]   arb_ptr, win;
  logic [N-1:0]   mask, m;
  logic           vld_n;
  logic [N-1:0]   gnt_n;
  logic [W-1:0]   enc_n;
  logic           hold;

  // bit i set iff i > idx
  function automatic logic [N-1:0] idx2mask_lx(
    input logic [W-1:0] idx
  );
    logic [N-1:0] mk;
    mk = '0;
    for (int i = 0; i < N; i++)
      mk[i] = (W'(i) > idx);
    return mk;
  endfunction

  function automatic logic [W-1:0] lowest(
    input logic [N-1:0] v
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) r = W'(i);
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(
    input logic [W-1:0] idx
  );
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++)
      oh[i] = (W'(i) == idx);
    return oh;
  endfunction

`ifdef RR_ARB_BURST_EN
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [BW-1:0] bcnt, bcnt_n;

  assign hold = req_i[gnt_enc_o] &&
                (int'(bcnt) < BURST - 1);

  always_comb begin
    bcnt_n = bcnt;
    if (state == GRANT && ack_i)
      bcnt_n = hold ? bcnt + BW'(1) : '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) bcnt <= '0;
    else         bcnt <= bcnt_n;
  end
`else
  assign hold = 1'b0;
`endif

  // On ack the pointer seen by arbitration is the winner being retired
  always_comb begin
    arb_ptr = (state == GRANT) ? gnt_enc_o : ptr;
    mask    = idx2mask_lx(arb_ptr);
    m       = req_i & mask;
    win     = (|m) ? lowest(m) : lowest(req_i);
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    vld_n   = gnt_vld_o;
    gnt_n   = gnt_o;
    enc_n   = gnt_enc_o;
    unique case (state)
      IDLE: begin
        if (|req_i) begin
          state_n = GRANT;
          vld_n   = 1'b1;
          gnt_n   = onehot(win);
          enc_n   = win;
        end
      end
      GRANT: begin
        if (ack_i && !hold) begin
          ptr_n = gnt_enc_o;
          if (|req_i) begin
            gnt_n = onehot(win);
            enc_n = win;
          end else begin
            state_n = IDLE;
            vld_n   = 1'b0;
            gnt_n   = '0;
            enc_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      ptr       <= W'(N - 1);
      gnt_vld_o <= 1'b0;
      gnt_o     <= '0;
      gnt_enc_o <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt_vld_o <= vld_n;
      gnt_o     <= gnt_n;
      gnt_enc_o <= enc_n;
    end
  end

endmodule

// File: tb/tb_rr_arb.sv
// Directed self-checking bench for rr_arb (N=4, BURST=3).
// Burst expectations follow RR_ARB_BURST_EN when defined.
module tb_rr_arb;

  logic       clk;
  logic       arst_n;
  logic [3:0] req_i;
  logic       ack_i;
  logic       gnt_vld_o;
  logic [3:0] gnt_o;
  logic [1:0] gnt_enc_o;

  int n_chk  = 0;
  int n_pass = 0;

  rr_arb #(.N(4), .BURST(3)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .gnt_vld_o (gnt_vld_o),
    .gnt_o     (gnt_o),
    .gnt_enc_o (gnt_enc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(
    input string tag,
    input logic  vld,
    input int    enc
  );
    logic [3:0] oh;
    oh = vld ? 4'(1 << enc) : 4'b0;
    chk({tag, ".vld"}, 32'(gnt_vld_o), 32'(vld));
    chk({tag, ".gnt"}, 32'(gnt_o), 32'(oh));
    chk({tag, ".enc"}, 32'(gnt_enc_o),
        vld ? 32'(enc) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq2[6];
  int seqb[7];

  initial begin
`ifdef RR_ARB_BURST_EN
    seq2 = '{0, 0, 0, 1, 1, 1};
    seqb = '{0, 0, 0, 1, 1, 1, 0};
`else
    seq2 = '{0, 1, 2, 3, 0, 1};
    seqb = '{0, 1, 0, 1, 0, 1, 0};
`endif
    arst_n = 1'b0;
    req_i  = 4'b0;
    ack_i  = 1'b0;
    #12;
    chk_gnt("reset", 1'b0, 0);
    arst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ack_i = i[0];
      step();
      chk_gnt($sformatf("idle%0d", i), 1'b0, 0);
    end

    req_i = 4'b1111;
    ack_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_gnt($sformatf("rr%0d", i), 1'b1, seq2[i]);
    end
    req_i = 4'b0;
    step();
    chk_gnt("rr_drain", 1'b0, 0);

    req_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_gnt($sformatf("solo%0d", i), 1'b1, 2);
    end
    req_i = 4'b0;
    step();
    chk_gnt("solo_drain", 1'b0, 0);

    ack_i = 1'b0;
    req_i = 4'b0010;
    step();
    chk_gnt("hold_first", 1'b1, 1);
    req_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_gnt($sformatf("hold%0d", i), 1'b1, 1);
    end
    ack_i = 1'b1;
    step();
    chk_gnt("hold_next", 1'b1, 3);
    ack_i = 1'b0;
    step();
    chk_gnt("hold_keep", 1'b1, 3);

    req_i = 4'b0100;
    ack_i = 1'b1;
    step();
    chk_gnt("wrap", 1'b1, 2);
    ack_i = 1'b0;
    #3;
    arst_n = 1'b0;
    #1;
    chk_gnt("async_rst", 1'b0, 0);
    #2;
    req_i  = 4'b1100;
    arst_n = 1'b1;
    step();
    chk_gnt("post_rst", 1'b1, 2);
    req_i = 4'b0;
    ack_i = 1'b1;
    step();
    chk_gnt("post_drain", 1'b0, 0);

    req_i = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_gnt($sformatf("pair%0d", i), 1'b1, seqb[i]);
    end
    req_i = 4'b0;
    step();
    chk_gnt("pair_drain", 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
